// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus initiator.
package mips_bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned BE_W  = BUS_W / 8;
  localparam logic [BUS_W-1:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {IDLE, BUS, RDATA} bus_state_t;

  typedef struct packed {
    logic             write;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BE_W-1:0]  be;
  } bus_req_t;

endpackage

// File: rtl/mips_bus_initiator.sv
// CPU-side initiator: runs one waitrequest-aware bus transfer per CPU request
// and returns read data, a write acknowledge, or an error response.
module mips_bus_initiator #(
  parameter int unsigned TIMEOUT = 256,
  parameter logic [mips_bus_pkg::BUS_W-1:0] RESET_VECTOR = mips_bus_pkg::RESET_VECTOR
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [mips_bus_pkg::BUS_W-1:0]  req_addr,
  input  logic [mips_bus_pkg::BUS_W-1:0]  req_wdata,
  input  logic [mips_bus_pkg::BE_W-1:0]   req_be,
  output logic                            resp_valid,
  output logic                            resp_error,
  output logic [mips_bus_pkg::BUS_W-1:0]  resp_rdata,
  output logic                            busy,
  output logic [mips_bus_pkg::BUS_W-1:0]  address,
  output logic                            read,
  output logic                            write,
  output logic [mips_bus_pkg::BUS_W-1:0]  writedata,
  output logic [mips_bus_pkg::BE_W-1:0]   byteenable,
  input  logic                            waitrequest,
  input  logic [mips_bus_pkg::BUS_W-1:0]  readdata
);

  import mips_bus_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t        state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_error_q, resp_error_d;
  logic [BUS_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  // Next-state and registered-output logic; req_q.be doubles as the bus byteenable
  // and is cleared whenever the strobe drops.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    read_d       = read_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
            read_d  = ~req_write;
            write_d = req_write;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_d   = 1'b0;
          write_d  = 1'b0;
          req_d.be = '0;
          if (req_q.write) begin
            resp_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RDATA;
          end
        end else if (cnt_q == CNT_LAST) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          req_d.be     = '0;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RDATA: begin
        resp_rdata_d = readdata;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '{write: 1'b0, addr: RESET_VECTOR, wdata: '0, be: '0};
      cnt_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      read_q       <= read_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = req_q.addr;
  assign writedata  = req_q.wdata;
  assign byteenable = req_q.be;
  assign read       = read_q;
  assign write      = write_q;

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Directed bench for mips_bus_initiator with a byte-lane RAM responder.
module tb_mips_bus_initiator;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int vec = 0;
  int bad = 0;
  int waits = 0;
  bit stuck = 1'b0;
  int wait_cnt;
  logic [31:0] ram [0:63];
  logic [5:0]  widx;

  mips_bus_initiator #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .busy(busy), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Responder: stalls 'waits' cycles per strobe (or forever when stuck).
  assign widx = address[7:2];
  assign waitrequest = stuck | ((read | write) && (wait_cnt < waits));

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0;
      readdata <= '0;
      for (int i = 0; i < 64; i++) ram[i] <= (i == 1) ? 32'h1234_5678 : 32'h0;
    end else if (read || write) begin
      if (waitrequest) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (write)
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) ram[widx][8*b +: 8] <= writedata[8*b +: 8];
        if (read) readdata <= ram[widx];
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its response, recording strobe activity.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat, output int rd_hi,
                          output int wr_hi, output bit overlap, output bit addr_bad,
                          output bit be_bad, output logic err, output logic [31:0] rdata);
    lat = 0; rd_hi = 0; wr_hi = 0; overlap = 0; addr_bad = 0; be_bad = 0;
    err = 1'b0; rdata = '0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      if (read) rd_hi++;
      if (write) wr_hi++;
      if (read && write) overlap = 1;
      if ((read || write) && address !== a) addr_bad = 1;
      if (!(read || write) && byteenable !== 4'b0000) be_bad = 1;
      if (resp_valid === 1'b1) begin
        lat = c; err = resp_error; rdata = resp_rdata;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    tick; tick; tick;
    reset = 1'b0;
    vec++; if (read !== 1'b0 || write !== 1'b0) begin bad++; $display("FAIL reset_strobes: got r=%b w=%b expected 0 0", read, write); end
    vec++; if (address !== BASE) begin bad++; $display("FAIL reset_address: got %h expected %h", address, BASE); end
    vec++; if (writedata !== 32'h0 || byteenable !== 4'h0) begin bad++; $display("FAIL reset_wd_be: got %h %h expected 0 0", writedata, byteenable); end
    vec++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected 0 0 0", resp_valid, resp_error, resp_rdata); end
    vec++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy: got rdy=%b busy=%b expected 1 0", req_ready, busy); end
  endtask

  task automatic test_read;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    waits = 0;
    run_xfer(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
    vec++; if (lat !== 3) begin bad++; $display("FAIL read_latency: got %0d expected 3", lat); end
    vec++; if (rh !== 1 || wh !== 0) begin bad++; $display("FAIL read_strobe_cycles: got rd=%0d wr=%0d expected 1 0", rh, wh); end
    vec++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL read_data: got %h expected 12345678", rd); end
    vec++; if (e !== 1'b0 || ab !== 1'b0 || bb !== 1'b0) begin bad++; $display("FAIL read_err_addr_be: got e=%b addr_bad=%b be_bad=%b expected 0 0 0", e, ab, bb); end
  endtask

  task automatic test_write_waits;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    waits = 3;
    run_xfer(1'b1, 32'hBFC0_0008, 32'hAABB_CCDD, 4'b0101, lat, rh, wh, ov, ab, bb, e, rd);
    vec++; if (wh !== 4 || rh !== 0) begin bad++; $display("FAIL write_strobe_cycles: got wr=%0d rd=%0d expected 4 0", wh, rh); end
    vec++; if (lat !== 5 || e !== 1'b0) begin bad++; $display("FAIL write_resp: got lat=%0d e=%b expected 5 0", lat, e); end
    vec++; if (ram[2] !== 32'h00BB_00DD) begin bad++; $display("FAIL write_ram: got %h expected 00bb00dd", ram[2]); end
    waits = 0;
    run_xfer(1'b0, 32'hBFC0_0008, 32'h0, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
    vec++; if (rd !== 32'h00BB_00DD || lat !== 3) begin bad++; $display("FAIL write_readback: got %h lat=%0d expected 00bb00dd 3", rd, lat); end
  endtask

  task automatic test_noop_write;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    waits = 0;
    run_xfer(1'b1, 32'hBFC0_0004, 32'hFFFF_FFFF, 4'b0000, lat, rh, wh, ov, ab, bb, e, rd);
    vec++; if (wh !== 1 || lat !== 2 || e !== 1'b0) begin bad++; $display("FAIL noop_write: got wr=%0d lat=%0d e=%b expected 1 2 0", wh, lat, e); end
    vec++; if (ram[1] !== 32'h1234_5678) begin bad++; $display("FAIL noop_ram: got %h expected 12345678", ram[1]); end
  endtask

  task automatic test_timeout;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    stuck = 1'b1;
    run_xfer(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
    stuck = 1'b0;
    vec++; if (lat !== 9 || e !== 1'b1) begin bad++; $display("FAIL timeout_resp: got lat=%0d e=%b expected 9 1", lat, e); end
    vec++; if (rh !== 8) begin bad++; $display("FAIL timeout_strobe: got %0d expected 8", rh); end
    vec++; if (read !== 1'b0 || byteenable !== 4'h0) begin bad++; $display("FAIL timeout_drop: got r=%b be=%h expected 0 0", read, byteenable); end
  endtask

  task automatic test_misaligned;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    run_xfer(1'b0, 32'hBFC0_0002, 32'h0, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
    vec++; if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL misaligned_resp: got lat=%0d e=%b expected 1 1", lat, e); end
    vec++; if (rh !== 0 || wh !== 0) begin bad++; $display("FAIL misaligned_strobe: got rd=%0d wr=%0d expected 0 0", rh, wh); end
  endtask

  task automatic test_reset_mid;
    int seen;
    waits = 4;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFC0_0010; req_be = 4'hF;
    tick;
    req_valid = 1'b0;
    tick; tick;
    vec++; if (read !== 1'b1) begin bad++; $display("FAIL midreset_pre: got r=%b expected 1", read); end
    reset = 1'b1;
    tick;
    vec++; if (read !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_drop: got r=%b busy=%b expected 0 0", read, busy); end
    vec++; if (address !== BASE) begin bad++; $display("FAIL midreset_addr: got %h expected %h", address, BASE); end
    reset = 1'b0;
    seen = (resp_valid === 1'b1) ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (resp_valid === 1'b1) seen++;
    end
    vec++; if (seen !== 0) begin bad++; $display("FAIL midreset_noresp: got %0d responses expected 0", seen); end
    waits = 0;
  endtask

  task automatic test_back_to_back;
    int lat, rh, wh; bit ov, ab, bb; logic e; logic [31:0] rd;
    logic [31:0] last [0:3];
    logic [31:0] a, d;
    bit any_ov = 0;
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'h20 + 32'(4 * ((i / 2) % 4));
      d = 32'hA500_0000 + 32'(i * 32'h0001_0101);
      waits = int'($urandom_range(0, 3));
      vec++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
      if (i % 2 == 0) begin
        run_xfer(1'b1, a, d, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
        last[(i / 2) % 4] = d;
        vec++; if (lat !== waits + 2 || e !== 1'b0) begin bad++; $display("FAIL b2b_write[%0d]: got lat=%0d e=%b expected %0d 0", i, lat, e, waits + 2); end
      end else begin
        run_xfer(1'b0, a, 32'h0, 4'hF, lat, rh, wh, ov, ab, bb, e, rd);
        vec++; if (lat !== waits + 3 || e !== 1'b0) begin bad++; $display("FAIL b2b_read_lat[%0d]: got lat=%0d e=%b expected %0d 0", i, lat, e, waits + 3); end
        vec++; if (rd !== last[(i / 2) % 4]) begin bad++; $display("FAIL b2b_read_data[%0d]: got %h expected %h", i, rd, last[(i / 2) % 4]); end
      end
      if (ov || ab || bb) any_ov = 1;
    end
    vec++; if (any_ov !== 1'b0) begin bad++; $display("FAIL b2b_bus_rules: got violation expected none"); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_waits;
    test_noop_write;
    test_timeout;
    test_misaligned;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
